csela_wide_seq: RTL and testbench

- Sequential multi-precision adder controller. Time-multiplexes one 8-bit carry-select adder slice over NBYTES bytes, least-significant byte first, so wide operands are added without a wide combinational adder.
- The slice is built the standard way from 4-bit ripple pairs, one computing with carry 0 and one with carry 1, plus sum/carry muxes, and it takes a carry-in.
- The block sits between a valid/ready producer and a valid/ready consumer in the arithmetic datapath.

---
 rtl/csela_wide_seq_if.sv | 38 +++
 rtl/csela_wide_seq.sv | 161 ++++++++++++++++
 tb/tb_csela_wide_seq.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csela_wide_seq_if.sv
// ============================================================================
// Module      : csela_wide_seq_if
// Description : Operand/result handshake bundle for csela_wide_seq.
//               master - producer/consumer side (drives operands, out_ready)
//               slave  - adder controller side (drives result, status)
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout)
//   busy                : controller is in RUN or DONE
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csela_wide_seq_if #(
  parameter int NBYTES = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   sum;
  logic                  cout;
  logic                  busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

`default_nettype wire

// File: rtl/csela_wide_seq.sv
// ============================================================================
// Module      : csela_wide_seq
// Description : Sequential multi-precision adder. One 8-bit carry-select
//               slice is reused over NBYTES bytes, LSB first; the byte carry
//               is passed between cycles through a register only.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - csela_wide_seq_if.slave (operand/result handshakes,
//                        sum/cout result, busy status)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csela_wide_seq #(
  parameter int NBYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  csela_wide_seq_if.slave    bus
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;
  logic [W-1:0]      sum_reg;
  logic              carry_reg;
  logic [IDXW-1:0]   idx;

  logic [7:0]        a_byte;
  logic [7:0]        b_byte;
  logic [4:0]        lo_c0;
  logic [4:0]        lo_c1;
  logic [4:0]        hi_c0;
  logic [4:0]        hi_c1;
  logic [4:0]        lo_sel;
  logic [4:0]        hi_sel;
  logic [7:0]        slice_sum;
  logic              slice_cout;

  // 4-bit ripple adder; result is {carry_out, sum[3:0]}.
  function automatic logic [4:0] ripple4(input logic [3:0] x,
                                         input logic [3:0] y,
                                         input logic       c);
    logic [4:0] r;
    logic       cc;
    r  = '0;
    cc = c;
    for (int i = 0; i < 4; i++) begin
      r[i] = x[i] ^ y[i] ^ cc;
      cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
    end
    r[4] = cc;
    return r;
  endfunction

  // Carry-select slice: each nibble is computed for both carry values in
  // parallel and the real incoming carry only drives the muxes.
  always_comb begin
    a_byte     = a_reg[8*idx +: 8];
    b_byte     = b_reg[8*idx +: 8];
    lo_c0      = ripple4(a_byte[3:0], b_byte[3:0], 1'b0);
    lo_c1      = ripple4(a_byte[3:0], b_byte[3:0], 1'b1);
    hi_c0      = ripple4(a_byte[7:4], b_byte[7:4], 1'b0);
    hi_c1      = ripple4(a_byte[7:4], b_byte[7:4], 1'b1);
    lo_sel     = carry_reg ? lo_c1 : lo_c0;
    hi_sel     = lo_sel[4] ? hi_c1 : hi_c0;
    slice_sum  = {hi_sel[3:0], lo_sel[3:0]};
    slice_cout = hi_sel[4];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (idx == LAST_IDX) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture and byte-serial accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            idx       <= '0;
          end
        end
        RUN: begin
          sum_reg[8*idx +: 8] <= slice_sum;
          carry_reg           <= slice_cout;
          // idx parks on the last byte instead of wrapping
          if (idx != LAST_IDX) begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.sum  = sum_reg;
  assign bus.cout = carry_reg;

endmodule

`default_nettype wire

// File: tb/tb_csela_wide_seq.sv
// ============================================================================
// Module      : tb_csela_wide_seq
// Description : Self-checking bench for csela_wide_seq (NBYTES=4 and 1).
//               Directed vector table, hand-written handshake/reset
//               sequences, back-to-back streaming and random operands
//               against a plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_csela_wide_seq;

  logic clk;
  logic rst_n;

  csela_wide_seq_if #(.NBYTES(4)) bus4 ();
  csela_wide_seq_if #(.NBYTES(1)) bus1 ();

  csela_wide_seq #(.NBYTES(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  csela_wide_seq #(.NBYTES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  vec_t        vecs [8];
  logic [32:0] res;
  logic [8:0]  res1;
  int          lat;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        rc;
  logic [32:0] exp_q [$];
  int          last_acc;
  int          pulses;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] model4(input logic [31:0] x, input logic [31:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + 33'(c);
  endfunction

  function automatic logic [8:0] model1(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + 9'(c);
  endfunction

  // Called at a negedge with dut4 idle. Operands are replaced by junk right
  // after the accept edge; lat = negedges until out_valid is seen.
  task automatic run4(input logic [31:0] x, input logic [31:0] y, input logic c,
                      input logic [31:0] junk, output logic [32:0] r, output int l);
    bus4.a         = x;
    bus4.b         = y;
    bus4.cin       = c;
    bus4.in_valid  = 1'b1;
    bus4.out_ready = 1'b0;
    l = 0;
    do begin
      @(negedge clk);
      l++;
      bus4.in_valid = 1'b0;
      bus4.a        = junk;
      bus4.b        = junk;
      bus4.cin      = ~c;
    end while (!bus4.out_valid && l < 20);
    r = {bus4.cout, bus4.sum};
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
  endtask

  task automatic run1(input logic [7:0] x, input logic [7:0] y, input logic c,
                      output logic [8:0] r, output int l);
    bus1.a         = x;
    bus1.b         = y;
    bus1.cin       = c;
    bus1.in_valid  = 1'b1;
    bus1.out_ready = 1'b0;
    l = 0;
    do begin
      @(negedge clk);
      l++;
      bus1.in_valid = 1'b0;
      bus1.a        = ~x;
      bus1.b        = ~y;
    end while (!bus1.out_valid && l < 20);
    r = {bus1.cout, bus1.sum};
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    vecs[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vecs[3] = '{32'h11111111, 32'h22222222, 1'b0, 32'h33333333, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};
    vecs[6] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};
    vecs[7] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};

    rst_n          = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.a         = '0;
    bus4.b         = '0;
    bus4.cin       = 1'b0;
    bus4.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.cin       = 1'b0;
    bus1.out_ready = 1'b0;

    // Asynchronous reset asserted mid-cycle, checked before any clock edge
    #3 rst_n = 1'b0;
    #1;
    check("rst_in_ready",  bus4.in_ready,  1);
    check("rst_out_valid", bus4.out_valid, 0);
    check("rst_busy",      bus4.busy,      0);
    check("rst_sum",       bus4.sum,       0);
    check("rst_cout",      bus4.cout,      0);
    check("rst1_in_ready", bus1.in_ready,  1);
    check("rst1_sum",      bus1.sum,       0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table (operands scrambled to 0x12345678 during RUN)
    for (int i = 0; i < 8; i++) begin
      run4(vecs[i].a, vecs[i].b, vecs[i].cin, 32'h12345678, res, lat);
      check($sformatf("vec%0d_sum", i),  res[31:0], vecs[i].sum);
      check($sformatf("vec%0d_cout", i), res[32],   vecs[i].cout);
      check($sformatf("vec%0d_latency", i), lat, 5);
      check($sformatf("vec%0d_idle_after", i), bus4.in_ready, 1);
    end

    // Backpressure: result held with out_ready=0 while in_valid stays high
    bus4.a         = 32'h11111111;
    bus4.b         = 32'h22222222;
    bus4.cin       = 1'b0;
    bus4.in_valid  = 1'b1;
    bus4.out_ready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus4.a = $urandom;
      bus4.b = $urandom;
    end while (!bus4.out_valid && lat < 20);
    check("bp_latency", lat, 5);
    for (int k = 0; k < 5; k++) begin
      check("bp_sum",       bus4.sum,       32'h33333333);
      check("bp_cout",      bus4.cout,      0);
      check("bp_in_ready",  bus4.in_ready,  0);
      check("bp_out_valid", bus4.out_valid, 1);
      @(negedge clk);
      bus4.a = $urandom;
    end
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 1'b0;
    @(negedge clk);
    check("bp_release_in_ready",  bus4.in_ready,  1);
    check("bp_release_out_valid", bus4.out_valid, 0);
    check("bp_release_sum_hold",  bus4.sum,       32'h33333333);
    bus4.out_ready = 1'b0;

    // Reset in the middle of RUN, after two RUN edges
    bus4.a        = 32'h01020304;
    bus4.b        = 32'h10203040;
    bus4.cin      = 1'b0;
    bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    check("mid_busy_before", bus4.busy, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",      bus4.busy,      0);
    check("mid_rst_in_ready",  bus4.in_ready,  1);
    check("mid_rst_out_valid", bus4.out_valid, 0);
    check("mid_rst_sum",       bus4.sum,       0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus4.out_valid) pulses++;
    end
    check("mid_rst_no_out_valid", pulses, 0);
    run4(32'hDEADBEEF, 32'h21524111, 1'b1, 32'h0, res, lat);
    check("mid_rst_next_op", res, model4(32'hDEADBEEF, 32'h21524111, 1'b1));

    // Back-to-back streaming with in_valid and out_ready held high
    exp_q.delete();
    last_acc       = -1;
    bus4.in_valid  = 1'b1;
    bus4.out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (bus4.out_valid) begin
        if (exp_q.size() == 0) check("b2b_unexpected_out", 1, 0);
        else check("b2b_result", {bus4.cout, bus4.sum}, exp_q.pop_front());
      end
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      bus4.a   = ra;
      bus4.b   = rb;
      bus4.cin = rc;
      if (bus4.in_ready) begin
        if (last_acc >= 0) check("b2b_spacing", k - last_acc, 6);
        last_acc = k;
        exp_q.push_back(model4(ra, rb, rc));
      end
      @(negedge clk);
    end
    bus4.in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus4.out_valid) begin
        if (exp_q.size() == 0) check("b2b_unexpected_out", 1, 0);
        else check("b2b_result", {bus4.cout, bus4.sum}, exp_q.pop_front());
      end
      @(negedge clk);
    end
    check("b2b_drained", exp_q.size(), 0);
    bus4.out_ready = 1'b0;

    // Random operands; every fourth pair uses b = ~a for long carry chains
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? ~ra : $urandom;
      rc = 1'($urandom);
      run4(ra, rb, rc, $urandom, res, lat);
      check("rand_result", res, model4(ra, rb, rc));
      check("rand_latency", lat, 5);
    end

    // Single-byte instance
    run1(8'hF0, 8'h10, 1'b0, res1, lat);
    check("nb1_sum",     res1[7:0], 8'h00);
    check("nb1_cout",    res1[8],   1);
    check("nb1_latency", lat,       2);
    check("nb1_idle_after", bus1.in_ready, 1);
    for (int i = 0; i < 50; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      run1(ra[7:0], rb[7:0], rc, res1, lat);
      check("nb1_rand_result", res1, model1(ra[7:0], rb[7:0], rc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
